// File: rtl/posit_pkg.sv
// Shared posit helpers: log2, regime-field width, special word constants.
package posit_pkg;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int posit_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Regime run-code width for an n-bit posit.
  function automatic int posit_bs(input int n);
    return posit_log2(n);
  endfunction

  function automatic logic [63:0] posit_zero(input int n);
    return 64'd0 & 64'(n);
  endfunction

  // NaR: sign bit set, everything else clear.
  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // Largest positive magnitude (n-1 bits of ones).
  function automatic logic [63:0] posit_maxpos_mag(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Smallest positive magnitude.
  function automatic logic [63:0] posit_minpos_mag(input int n);
    return 64'd1 | (64'(n) & 64'd0);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on a posit magnitude, clamped to [minpos, maxpos].
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int M = 7
) (
  input  logic [M-1:0] mag,
  input  logic         guard,
  input  logic         sticky,
  output logic [M-1:0] mag_rounded
);

  localparam logic [M-1:0] MINPOS_MAG = M'(posit_minpos_mag(M + 1));

  logic [M:0] sum;

  // Increment on guard & (sticky | lsb); a carry out or a zero result is clamped.
  always_comb begin
    sum = {1'b0, mag} + {{M{1'b0}}, guard & (sticky | mag[0])};
    if (sum[M]) begin
      mag_rounded = '1;
    end else if (sum[M-1:0] == '0) begin
      mag_rounded = MINPOS_MAG;
    end else begin
      mag_rounded = sum[M-1:0];
    end
  end

endmodule

// File: rtl/posit_encode.sv
// Three-stage posit packer: decoded fields in, rounded N-bit posit word out.
module posit_encode
  import posit_pkg::*;
#(
  parameter int  N  = 8,
  parameter int  es = 2,
  localparam int Bs = posit_bs(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic          in_rc,
  input  logic [Bs-1:0] in_regime,
  input  logic [es-1:0] in_exp,
  input  logic [N-es-1:0] in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam int W  = 2 * N;   // shifter width
  localparam int M  = N - 1;   // magnitude width
  localparam int RW = Bs + 1;  // run length / shift amount width

  localparam logic [M-1:0] MAXPOS_MAG = M'(posit_maxpos_mag(N));
  localparam logic [M-1:0] MINPOS_MAG = M'(posit_minpos_mag(N));
  localparam logic [N-1:0] NAR_WORD   = N'(posit_nar(N));
  localparam logic [N-1:0] ZERO_WORD  = N'(posit_zero(N));

  logic en;

  // Stage 1 registers
  logic          s1_valid_reg, s1_zero_reg, s1_nar_reg, s1_sign_reg, s1_rc_reg, s1_sat_reg;
  logic [W-1:0]  s1_pattern_reg;
  logic [RW-1:0] s1_shamt_reg;
  logic [N-1:0]  s1_fields_reg;
  logic [RW-1:0] run_len_next, shamt_next;
  logic [W-1:0]  pattern_next;
  logic          sat_next;

  // Stage 2 registers
  logic          s2_valid_reg, s2_zero_reg, s2_nar_reg, s2_sign_reg;
  logic [M-1:0]  s2_mag_reg;
  logic          s2_guard_reg, s2_sticky_reg;
  logic [W-1:0]  body_next;
  logic [M-1:0]  mag_next;
  logic          guard_next, sticky_next;

  // Stage 3 registers
  logic          out_valid_reg;
  logic [N-1:0]  out_posit_reg;
  logic [M-1:0]  mag_rounded;
  logic [N-1:0]  word_pos, out_next;

  assign en        = !out_valid_reg || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_reg;
  assign out_posit = out_posit_reg;

  // Regime run length, saturation test, run/terminator pattern and shift amount.
  always_comb begin
    run_len_next = in_rc ? ({1'b0, in_regime} + RW'(1)) : {1'b0, in_regime};
    sat_next     = (run_len_next >= RW'(N - 1));
    pattern_next = in_rc ? ~({W{1'b1}} >> run_len_next)
                         : ({1'b1, {(W-1){1'b0}}} >> run_len_next);
    shamt_next   = run_len_next + RW'(1);
  end

  // Stage 1: capture fields with the precomputed regime pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_zero_reg    <= 1'b0;
      s1_nar_reg     <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_rc_reg      <= 1'b0;
      s1_sat_reg     <= 1'b0;
      s1_pattern_reg <= '0;
      s1_shamt_reg   <= '0;
      s1_fields_reg  <= '0;
    end else if (en) begin
      s1_valid_reg   <= in_valid;
      s1_zero_reg    <= in_zero;
      s1_nar_reg     <= in_nar;
      s1_sign_reg    <= in_sign;
      s1_rc_reg      <= in_rc;
      s1_sat_reg     <= sat_next;
      s1_pattern_reg <= pattern_next;
      s1_shamt_reg   <= shamt_next;
      s1_fields_reg  <= {in_exp, in_mant};
    end
  end

  // Place exp||mant after the terminator; split into magnitude, guard, sticky.
  always_comb begin
    body_next   = s1_pattern_reg | ({s1_fields_reg, {N{1'b0}}} >> s1_shamt_reg);
    mag_next    = body_next[W-1 -: M];
    guard_next  = body_next[N];
    sticky_next = |body_next[N-1:0];
    if (s1_sat_reg) begin
      mag_next    = s1_rc_reg ? MAXPOS_MAG : MINPOS_MAG;
      guard_next  = 1'b0;
      sticky_next = 1'b0;
    end
  end

  // Stage 2: register the unrounded magnitude and rounding bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_zero_reg   <= 1'b0;
      s2_nar_reg    <= 1'b0;
      s2_sign_reg   <= 1'b0;
      s2_mag_reg    <= '0;
      s2_guard_reg  <= 1'b0;
      s2_sticky_reg <= 1'b0;
    end else if (en) begin
      s2_valid_reg  <= s1_valid_reg;
      s2_zero_reg   <= s1_zero_reg;
      s2_nar_reg    <= s1_nar_reg;
      s2_sign_reg   <= s1_sign_reg;
      s2_mag_reg    <= mag_next;
      s2_guard_reg  <= guard_next;
      s2_sticky_reg <= sticky_next;
    end
  end

  posit_round_rne #(
    .M (M)
  ) u_round (
    .mag         (s2_mag_reg),
    .guard       (s2_guard_reg),
    .sticky      (s2_sticky_reg),
    .mag_rounded (mag_rounded)
  );

  // Apply specials and sign to the rounded magnitude.
  always_comb begin
    word_pos = {1'b0, mag_rounded};
    if (s2_zero_reg) begin
      out_next = ZERO_WORD;
    end else if (s2_nar_reg) begin
      out_next = NAR_WORD;
    end else if (s2_sign_reg) begin
      out_next = -word_pos;
    end else begin
      out_next = word_pos;
    end
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_posit_reg <= '0;
    end else if (en) begin
      out_valid_reg <= s2_valid_reg;
      out_posit_reg <= out_next;
    end
  end

endmodule

// File: tb/tb_posit_encode.sv
// Directed bench for posit_encode (N=8, es=2) with an in-order output scoreboard.
module tb_posit_encode;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sign, in_zero, in_nar, in_rc;
  logic [2:0] in_regime;
  logic [1:0] in_exp;
  logic [5:0] in_mant;
  logic       out_valid, out_ready;
  logic [7:0] out_posit;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held;

  logic       x_zero, x_nar, x_sign, x_rc;
  logic [2:0] x_reg;
  logic [1:0] x_exp;
  logic [5:0] x_mant;

  // {zero, nar, sign, rc, regime[2:0], exp[1:0], mant[5:0], expected[7:0]}
  localparam logic [22:0] VEC [15] = '{
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 6'b000000, 8'h40},
    {1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 2'b00, 6'b000000, 8'hC0},
    {1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'b11, 6'b101000, 8'h3D},
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b01, 6'b111100, 8'h50},
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 2'b00, 6'b000000, 8'h7F},
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 2'b11, 6'b000000, 8'h7F},
    {1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, 6'b000000, 8'h01},
    {1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 2'b00, 6'b111111, 8'h01},
    {1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 2'b10, 6'b101101, 8'h00},
    {1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 2'b01, 6'b010101, 8'h80},
    {1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 2'b11, 6'b111111, 8'h00},
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 6'b000100, 8'h40},
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 6'b001100, 8'h42},
    {1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'b11, 6'b101000, 8'hC3},
    {1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'b11, 6'b000000, 8'h7F}
  };

  localparam int BP_IDX [6] = '{0, 2, 3, 1, 6, 13};

  posit_encode #(
    .N  (8),
    .es (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_rc     (in_rc),
    .in_regime (in_regime),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Output scoreboard: every output handshake must match the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        $display("[TB] out 0x%02h expected 0x%02h", out_posit, exp_q[0]);
        check("out_word", 32'(out_posit), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  // Present one word; called just after a rising edge, returns just after its handshake edge.
  task automatic drive(input logic z, input logic nar, input logic sgn, input logic rc,
                       input logic [2:0] rg, input logic [1:0] e, input logic [5:0] m,
                       input logic [7:0] want);
    int   waited;
    logic acc;
    waited = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_zero = z; in_nar = nar; in_sign = sgn; in_rc = rc;
    in_regime = rg; in_exp = e; in_mant = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(want);
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 100);
    if (!acc) check("in_ready_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drive_vec(input logic [22:0] v);
    drive(v[22], v[21], v[20], v[19], v[18:16], v[15:14], v[13:8], v[7:0]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int w;
    w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 100) begin @(posedge clk); #1; w++; end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Reference field extractor: posit word -> decoded fields.
  task automatic extract(input logic [7:0] p, output logic z, output logic nar,
                         output logic sgn, output logic rc, output logic [2:0] rg,
                         output logic [1:0] e, output logic [5:0] m);
    logic [7:0]  neg;
    logic [6:0]  mag;
    logic [15:0] t;
    logic        run;
    int          k;
    z   = (p == 8'h00);
    nar = (p == 8'h80);
    sgn = p[7];
    neg = -p;
    mag = p[7] ? neg[6:0] : p[6:0];
    k   = 0;
    run = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      if (run && mag[i] == mag[6]) k++;
      else run = 1'b0;
    end
    rc = mag[6];
    rg = rc ? 3'(k - 1) : 3'(k);
    t  = {mag, 9'b0} << (k + 1);
    e  = t[15:14];
    m  = t[13:8];
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    in_rc = 1'b0; in_regime = '0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", 32'(out_posit), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    idle(1);

    // Directed vectors, streamed back to back
    for (int i = 0; i < 15; i++) drive_vec(VEC[i]);
    drain();

    // Extract-then-encode identity over every 8-bit posit
    for (int p = 0; p < 256; p++) begin
      extract(8'(p), x_zero, x_nar, x_sign, x_rc, x_reg, x_exp, x_mant);
      drive(x_zero, x_nar, x_sign, x_rc, x_reg, x_exp, x_mant, 8'(p));
    end
    drain();

    // Back-pressure: stall output for 5 cycles after the first word leaves
    fork
      begin
        for (int i = 0; i < 6; i++) drive_vec(VEC[BP_IDX[i]]);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        check("bp_first_out", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = out_posit;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
          check("bp_out_stable", 32'(out_posit), 32'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three words in flight and the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_vec(VEC[i]);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_flush_out_valid", 32'(out_valid), 32'd0);
    check("rst_flush_out_posit", 32'(out_posit), 32'd0);
    check("rst_flush_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(8);
    check("rst_no_stale", 32'(out_valid), 32'd0);
    drive_vec(VEC[2]);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
